// File: rtl/qu_common_pkg.sv
// Shared core-wide constants and types used by the reservation-station scheduler.
package qu_common;

    localparam int RES_ST_DEPTH = 8;

    typedef logic [$clog2(RES_ST_DEPTH)-1:0] res_st_addr_t;

endpackage

// File: rtl/res_st_sched_if.sv
// Rename/CDB/execute-side signal bundle of the reservation-station scheduler.
interface res_st_sched_if
    import qu_common::*;
#(
    parameter int DEPTH = RES_ST_DEPTH
) ();

    logic                     alloc_valid;
    logic                     alloc_ready;
    res_st_addr_t             alloc_idx;
    res_st_addr_t             alloc_qj;
    res_st_addr_t             alloc_qk;
    logic                     alloc_j_rdy;
    logic                     alloc_k_rdy;
    logic                     cdb_valid;
    res_st_addr_t             cdb_tag;
    logic                     issue_valid;
    res_st_addr_t             issue_idx;
    logic                     issue_ready;
    logic                     flush;
    logic [$clog2(DEPTH):0]   occupancy;

    modport master (
        output alloc_valid, alloc_qj, alloc_qk, alloc_j_rdy, alloc_k_rdy,
        output cdb_valid, cdb_tag, issue_ready, flush,
        input  alloc_ready, alloc_idx, issue_valid, issue_idx, occupancy
    );

    modport slave (
        input  alloc_valid, alloc_qj, alloc_qk, alloc_j_rdy, alloc_k_rdy,
        input  cdb_valid, cdb_tag, issue_ready, flush,
        output alloc_ready, alloc_idx, issue_valid, issue_idx, occupancy
    );

endinterface

// File: rtl/res_st_sched_pick.sv
// Issue selector for res_st_sched: oldest-eligible when QU_RES_ST_SCHED_AGE_EN is
// defined, otherwise round-robin starting at i_ptr.
module res_st_pick
    import qu_common::*;
#(
    parameter int DEPTH = RES_ST_DEPTH
) (
    input  logic [DEPTH-1:0]            i_eligible,
`ifdef QU_RES_ST_SCHED_AGE_EN
    input  logic [DEPTH-1:0][DEPTH-1:0] i_age,
`else
    input  res_st_addr_t                i_ptr,
`endif
    output res_st_addr_t                o_idx,
    output logic                        o_valid
);

    assign o_valid = |i_eligible;

`ifdef QU_RES_ST_SCHED_AGE_EN
    logic [DEPTH-1:0] w_oldest;

    // i_age[j][i] set means entry j was allocated before entry i.
    always_comb begin
        w_oldest = i_eligible;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (i_eligible[j] && i_age[j][i]) w_oldest[i] = 1'b0;
            end
        end
        o_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_oldest[i]) o_idx = res_st_addr_t'(i);
        end
    end
`else
    logic         w_found;
    res_st_addr_t w_cand;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        o_idx   = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_cand = i_ptr + res_st_addr_t'(k);
            if (!w_found && i_eligible[w_cand]) begin
                o_idx   = w_cand;
                w_found = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/res_st_sched.sv
// Reservation-station scheduler: allocation, CDB wakeup and issue selection.
// Define QU_RES_ST_SCHED_AGE_EN for oldest-first issue; default is round-robin.
module res_st_sched
    import qu_common::*;
#(
    parameter int DEPTH = RES_ST_DEPTH
) (
    input  logic          clk,
    input  logic          rst_n,
    res_st_sched_if.slave bus
);

    localparam int OW = $clog2(DEPTH) + 1;

    logic [DEPTH-1:0] r_busy, r_j_rdy, r_k_rdy;
    res_st_addr_t     r_qj [DEPTH];
    res_st_addr_t     r_qk [DEPTH];
    logic [OW-1:0]    r_occ;
    logic             r_hold;
    res_st_addr_t     r_hold_idx;

    logic             w_alloc_ready, w_alloc_fire, w_issue_fire, w_pick_valid;
    res_st_addr_t     w_alloc_idx, w_pick_idx, w_issue_idx;
    logic [DEPTH-1:0] w_eligible;

`ifdef QU_RES_ST_SCHED_AGE_EN
    logic [DEPTH-1:0][DEPTH-1:0] r_age;
`else
    res_st_addr_t                r_rr_ptr;
`endif

    // NOTE: blocking assignments in combinational logic; the downward scan leaves the lowest free index.
    always_comb begin
        w_alloc_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!r_busy[i]) w_alloc_idx = res_st_addr_t'(i);
        end
    end

    assign w_alloc_ready = (r_occ != OW'(DEPTH));
    assign w_eligible    = r_busy & r_j_rdy & r_k_rdy;
    assign w_alloc_fire  = bus.alloc_valid && w_alloc_ready;
    assign w_issue_fire  = w_pick_valid && bus.issue_ready;
    // A stalled grant is pinned so a later wakeup cannot steal the slot.
    assign w_issue_idx   = r_hold ? r_hold_idx : w_pick_idx;

    res_st_pick #(.DEPTH(DEPTH)) u_pick (
        .i_eligible (w_eligible),
`ifdef QU_RES_ST_SCHED_AGE_EN
        .i_age      (r_age),
`else
        .i_ptr      (r_rr_ptr),
`endif
        .o_idx      (w_pick_idx),
        .o_valid    (w_pick_valid)
    );

    // NOTE: sequential state uses non-blocking assignments; tag arrays are reset too so reset leaves no residue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy  <= '0;
            r_j_rdy <= '0;
            r_k_rdy <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_qj[i] <= '0;
                r_qk[i] <= '0;
            end
        end else if (bus.flush) begin
            r_busy <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r_busy[i] && bus.cdb_valid && (r_qj[i] == bus.cdb_tag)) r_j_rdy[i] <= 1'b1;
                if (r_busy[i] && bus.cdb_valid && (r_qk[i] == bus.cdb_tag)) r_k_rdy[i] <= 1'b1;
            end
            if (w_issue_fire) r_busy[w_issue_idx] <= 1'b0;
            if (w_alloc_fire) begin
                r_busy[w_alloc_idx]  <= 1'b1;
                r_qj[w_alloc_idx]    <= bus.alloc_qj;
                r_qk[w_alloc_idx]    <= bus.alloc_qk;
                r_j_rdy[w_alloc_idx] <= bus.alloc_j_rdy || (bus.cdb_valid && (bus.alloc_qj == bus.cdb_tag));
                r_k_rdy[w_alloc_idx] <= bus.alloc_k_rdy || (bus.cdb_valid && (bus.alloc_qk == bus.cdb_tag));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occ <= '0;
        end else if (bus.flush) begin
            r_occ <= '0;
        end else if (w_alloc_fire && !w_issue_fire) begin
            r_occ <= r_occ + 1'b1;
        end else if (!w_alloc_fire && w_issue_fire) begin
            r_occ <= r_occ - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold     <= 1'b0;
            r_hold_idx <= '0;
        end else if (bus.flush) begin
            r_hold     <= 1'b0;
        end else begin
            r_hold     <= w_pick_valid && !bus.issue_ready;
            r_hold_idx <= w_issue_idx;
        end
    end

`ifdef QU_RES_ST_SCHED_AGE_EN
    // A new entry is younger than every other entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_age <= '0;
        end else if (!bus.flush && w_alloc_fire) begin
            for (int j = 0; j < DEPTH; j++) begin
                r_age[w_alloc_idx][j] <= 1'b0;
                r_age[j][w_alloc_idx] <= (res_st_addr_t'(j) != w_alloc_idx);
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else if (!bus.flush && w_issue_fire) begin
            r_rr_ptr <= w_issue_idx + 1'b1;
        end
    end
`endif

    assign bus.alloc_ready = w_alloc_ready;
    assign bus.alloc_idx   = w_alloc_idx;
    assign bus.issue_valid = w_pick_valid;
    assign bus.issue_idx   = w_issue_idx;
    assign bus.occupancy   = r_occ;

endmodule

// File: tb/tb_res_st_sched.sv
// Self-checking bench for res_st_sched against a queue-based scheduling model.
module tb_res_st_sched;
    import qu_common::*;

    localparam int D = RES_ST_DEPTH;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    res_st_sched_if #(.DEPTH(D)) bus ();
    res_st_sched #(.DEPTH(D)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // Reference model: entry table plus allocation-order queue.
    bit m_busy [D];
    bit m_jr   [D];
    bit m_kr   [D];
    int m_qj   [D];
    int m_qk   [D];
    int m_order[$];
    int m_ptr;
    bit m_hold;
    int m_hold_idx;
    int m_last_issue;

    int e_occ, e_aidx, e_iidx;
    bit e_ardy, e_ivld;

    int n_cmp  = 0;
    int n_fail = 0;
    int issued_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < D; i++) begin
            m_busy[i] = 0; m_jr[i] = 0; m_kr[i] = 0; m_qj[i] = 0; m_qk[i] = 0;
        end
        m_order.delete();
        m_ptr = 0; m_hold = 0; m_hold_idx = 0; m_last_issue = 0;
    endfunction

    function automatic bit elig(input int i);
        return m_busy[i] && m_jr[i] && m_kr[i];
    endfunction

    function automatic void model_expect();
        e_occ = 0; e_aidx = -1; e_ivld = 0; e_iidx = 0;
        for (int i = 0; i < D; i++) begin
            if (m_busy[i]) e_occ++;
            else if (e_aidx < 0) e_aidx = i;
            if (elig(i)) e_ivld = 1;
        end
        if (e_aidx < 0) e_aidx = 0;
        e_ardy = (e_occ != D);
        if (m_hold) begin
            e_iidx = m_hold_idx;
        end else if (e_ivld) begin
`ifdef QU_RES_ST_SCHED_AGE_EN
            foreach (m_order[n]) begin
                if (elig(m_order[n])) begin e_iidx = m_order[n]; break; end
            end
`else
            for (int k = 0; k < D; k++) begin
                if (elig((m_ptr + k) % D)) begin e_iidx = (m_ptr + k) % D; break; end
            end
`endif
        end
    endfunction

    function automatic void model_next();
        bit fire_i, fire_a;
        int a;
        if (bus.flush) begin
            for (int i = 0; i < D; i++) m_busy[i] = 0;
            m_order.delete();
            m_hold = 0;
            return;
        end
        fire_i = e_ivld && bus.issue_ready;
        fire_a = bus.alloc_valid && e_ardy;
        for (int i = 0; i < D; i++) begin
            if (m_busy[i] && bus.cdb_valid && m_qj[i] == int'(bus.cdb_tag)) m_jr[i] = 1;
            if (m_busy[i] && bus.cdb_valid && m_qk[i] == int'(bus.cdb_tag)) m_kr[i] = 1;
        end
        if (fire_i) begin
            m_busy[e_iidx] = 0;
            foreach (m_order[n]) if (m_order[n] == e_iidx) begin m_order.delete(n); break; end
            m_ptr = (e_iidx + 1) % D;
            m_last_issue = e_iidx;
        end
        if (fire_a) begin
            a = e_aidx;
            m_busy[a] = 1;
            m_qj[a] = int'(bus.alloc_qj);
            m_qk[a] = int'(bus.alloc_qk);
            m_jr[a] = bus.alloc_j_rdy || (bus.cdb_valid && bus.alloc_qj == bus.cdb_tag);
            m_kr[a] = bus.alloc_k_rdy || (bus.cdb_valid && bus.alloc_qk == bus.cdb_tag);
            m_order.push_back(a);
        end
        m_hold = e_ivld && !bus.issue_ready;
        m_hold_idx = e_iidx;
    endfunction

    task automatic drive(input bit av, input int qj, input bit jr, input int qk, input bit kr,
                         input bit cv, input int tag, input bit ir, input bit fl);
        bus.alloc_valid = av;
        bus.alloc_qj    = res_st_addr_t'(qj);
        bus.alloc_j_rdy = jr;
        bus.alloc_qk    = res_st_addr_t'(qk);
        bus.alloc_k_rdy = kr;
        bus.cdb_valid   = cv;
        bus.cdb_tag     = res_st_addr_t'(tag);
        bus.issue_ready = ir;
        bus.flush       = fl;
    endtask

    // One clock: compare outputs against the model, advance model, cross the edge.
    task automatic step(input string tag);
        model_expect();
        check({tag, ".occ"},  32'(bus.occupancy),   32'(e_occ));
        check({tag, ".ardy"}, 32'(bus.alloc_ready), 32'(e_ardy));
        if (e_ardy) check({tag, ".aidx"}, 32'(bus.alloc_idx), 32'(e_aidx));
        check({tag, ".ivld"}, 32'(bus.issue_valid), 32'(e_ivld));
        if (e_ivld) check({tag, ".iidx"}, 32'(bus.issue_idx), 32'(e_iidx));
        if (bus.issue_valid === 1'b1 && bus.issue_ready) issued_q.push_back(int'(bus.issue_idx));
        model_next();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".occ"},  32'(bus.occupancy),   32'd0);
        check({tag, ".ivld"}, 32'(bus.issue_valid), 32'd0);
        check({tag, ".ardy"}, 32'(bus.alloc_ready), 32'd1);
        check({tag, ".aidx"}, 32'(bus.alloc_idx),   32'd0);
        check({tag, ".iidx"}, 32'(bus.issue_idx),   32'd0);
    endtask

    initial begin
        int exp_order[3];
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        @(posedge clk);
        #1;
        check_reset_vals("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Ready-at-alloc uop issues the next cycle.
        drive(1, 0, 1, 0, 1, 0, 0, 1, 0);  step("rdy_alloc");
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);  step("rdy_issue");
        step("rdy_drain");

        // Wakeup on tag 3 at cycle 5; tag 2 must not wake.
        drive(1, 3, 0, 0, 1, 0, 0, 1, 0);  step("wake_c0");
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);  step("wake_c1");
        drive(0, 0, 0, 0, 0, 1, 2, 1, 0);  step("wake_c2");
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);  step("wake_c3");
        step("wake_c4");
        drive(0, 0, 0, 0, 0, 1, 3, 1, 0);  step("wake_c5");
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);  step("wake_c6");
        step("wake_c7");

        // Alloc coinciding with matching CDB is stored ready.
        drive(1, 4, 0, 6, 1, 1, 4, 1, 0);  step("same_c0");
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);  step("same_c1");
        step("same_c2");

        // Fill all entries while stalled, then free one and reuse it.
        for (int i = 0; i < D; i++) begin
            drive(1, i, 1, i, 1, 0, 0, 0, 0);
            step("fill");
        end
        check("full.ardy", 32'(bus.alloc_ready), 32'd0);
        check("full.occ",  32'(bus.occupancy),   32'(D));
        drive(1, 1, 1, 1, 1, 0, 0, 0, 0);  step("full_ign");
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);  step("full_issue");
        check("reuse.ardy", 32'(bus.alloc_ready), 32'd1);
        check("reuse.aidx", 32'(bus.alloc_idx),   32'(m_last_issue));
        drive(1, 0, 1, 0, 1, 0, 0, 0, 0);  step("reuse_alloc");
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < D + 2; i++) step("drain");

        // Allocate entries 2, 5, 1 in that order, then release them together.
        for (int i = 0; i < D; i++) begin
            drive(1, i, 0, 0, 1, 0, 0, 1, 0);
            step("park");
        end
        foreach (exp_order[n]) begin
            drive(0, 0, 0, 0, 0, 1, (n == 0) ? 2 : (n == 1) ? 5 : 1, 1, 0);  step("free_w");
            drive(0, 0, 0, 0, 0, 0, 0, 1, 0);                               step("free_i");
            drive(1, 2, 0, 0, 1, 0, 0, 1, 0);                               step("realloc");
        end
        drive(0, 0, 0, 0, 0, 1, 0, 1, 0);  step("ptr_w");
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);  step("ptr_i");
        step("ptr_idle");
        issued_q.delete();
        drive(0, 0, 0, 0, 0, 1, 2, 1, 0);  step("order_w");
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) step("order_i");
`ifdef QU_RES_ST_SCHED_AGE_EN
        exp_order = '{2, 5, 1};
`else
        exp_order = '{1, 2, 5};
`endif
        check("order.n", 32'(issued_q.size()), 32'd3);
        foreach (exp_order[n])
            check($sformatf("order.%0d", n), (issued_q.size() > n) ? 32'(issued_q[n]) : 32'hFFFF_FFFF, 32'(exp_order[n]));

        // Flush with four busy entries and a simultaneous alloc.
        check("preflush.occ", 32'(bus.occupancy), 32'd4);
        drive(1, 0, 1, 0, 1, 1, 3, 1, 1);  step("flush");
        check("flush.occ",  32'(bus.occupancy),   32'd0);
        check("flush.ivld", 32'(bus.issue_valid), 32'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);  step("post_flush");

        // Randomized traffic.
        for (int c = 0; c < 600; c++) begin
            drive(($urandom % 3) != 0, $urandom % D, $urandom % 2, $urandom % D, $urandom % 2,
                  $urandom % 2, $urandom % D, ($urandom % 4) != 0, ($urandom % 64) == 0);
            step("rand");
        end

        // Asynchronous reset in the middle of traffic.
        for (int c = 0; c < 6; c++) begin
            drive(1, $urandom % D, 0, $urandom % D, 1, 0, 0, 0, 0);
            step("prefill");
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        model_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1, 0, 1, 0, 1, 0, 0, 1, 0);  step("after_rst_a");
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);  step("after_rst_i");
        step("after_rst_d");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
